// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer: frame controller for the pixel array.
// Sequences erase/expose/convert phases with programmable durations,
// then reads the array row by row and streams pixels over valid/ready.
//
// Ports:
//   clock, reset        : rising-edge clock, async active-low reset
//   cfg_we/addr/wdata   : duration register writes (accepted in IDLE only)
//                         addr 0=t_erase 1=t_expose 2=t_convert 3=reserved
//   start, continuous   : frame launch and auto-restart at frame end
//   abort               : synchronous abort of the frame in progress
//   busy, frame_done    : status; frame_done pulses once per completed frame
//   erase/expose/convert: mutually exclusive phase strobes
//   read                : one-hot row select during readout
//   pix_row_data        : ADC bus of the selected row, pixel c at [c*DW +: DW]
//   out_valid/out_ready : pixel stream handshake
//   out_data/row/col    : pixel sample and its coordinates
module pixel_frame_sequencer #(
    parameter int ROW = 4,
    parameter int COL = 4,
    parameter int DW  = 8,
    parameter int CW  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_addr,
    input  logic [CW-1:0]          cfg_wdata,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   abort,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   erase,
    output logic                   expose,
    output logic                   convert,
    output logic [ROW-1:0]         read,
    input  logic [COL*DW-1:0]      pix_row_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(ROW)-1:0] out_row,
    output logic [$clog2(COL)-1:0] out_col
);

    localparam int RW = $clog2(ROW);
    localparam int KW = $clog2(COL);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
    localparam logic [KW-1:0] COL_LAST = KW'(COL - 1);
    localparam logic [CW-1:0] T_ERASE_RST  = CW'(5);
    localparam logic [CW-1:0] T_EXPOSE_RST = CW'(255);
    localparam logic [CW-1:0] T_CONV_RST   = CW'(255);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_RD_SEL,
        S_RD_CAP,
        S_RD_OUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     t_erase_q, t_erase_d;
    logic [CW-1:0]     t_expose_q, t_expose_d;
    logic [CW-1:0]     t_convert_q, t_convert_d;
    logic [RW-1:0]     row_q, row_d;
    logic [KW-1:0]     col_q, col_d;
    logic [COL*DW-1:0] cap_q, cap_d;

    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              erase_q, erase_d;
    logic              expose_q, expose_d;
    logic              convert_q, convert_d;
    logic [ROW-1:0]    read_q, read_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [RW-1:0]     out_row_q, out_row_d;
    logic [KW-1:0]     out_col_q, out_col_d;

    logic [CW-1:0]     t_cur;
    logic              phase_last;
    logic              beat;

    assign beat = out_valid_q && out_ready;

    // Duration of the phase currently running.
    always_comb begin
        case (state_q)
            S_ERASE:   t_cur = t_erase_q;
            S_EXPOSE:  t_cur = t_expose_q;
            S_CONVERT: t_cur = t_convert_q;
            default:   t_cur = '0;
        endcase
    end

    // A zero duration runs for one cycle, same as a duration of one.
    assign phase_last = (t_cur == '0) ? (cnt_q == '0)
                                      : (cnt_q == t_cur - 1'b1);

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        cap_d       = cap_q;
        t_erase_d   = t_erase_q;
        t_expose_d  = t_expose_q;
        t_convert_d = t_convert_q;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    case (cfg_addr)
                        2'd0:    t_erase_d   = cfg_wdata;
                        2'd1:    t_expose_d  = cfg_wdata;
                        2'd2:    t_convert_d = cfg_wdata;
                        default: ;
                    endcase
                end
                if (start && !abort) begin
                    state_d = S_ERASE;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_ERASE: begin
                if (phase_last) begin
                    state_d = S_EXPOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXPOSE: begin
                if (phase_last) begin
                    state_d = S_CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CONVERT: begin
                if (phase_last) begin
                    state_d = S_RD_SEL;
                    cnt_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_SEL: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                cap_d   = pix_row_data;
                col_d   = '0;
                state_d = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (beat) begin
                    if (col_q == COL_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = S_RD_SEL;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (continuous) begin
                    state_d = S_ERASE;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a pending handshake.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they register
    // alongside it and stay glitch-free.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
        erase_d      = (state_d == S_ERASE);
        expose_d     = (state_d == S_EXPOSE);
        convert_d    = (state_d == S_CONVERT);
        read_d       = '0;
        if (state_d inside {S_RD_SEL, S_RD_CAP, S_RD_OUT}) begin
            read_d[row_d] = 1'b1;
        end
        out_valid_d = (state_d == S_RD_OUT);
        out_data_d  = '0;
        out_row_d   = '0;
        out_col_d   = '0;
        if (out_valid_d) begin
            out_data_d = cap_d[int'(col_d)*DW +: DW];
            out_row_d  = row_d;
            out_col_d  = col_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            t_erase_q    <= T_ERASE_RST;
            t_expose_q   <= T_EXPOSE_RST;
            t_convert_q  <= T_CONV_RST;
            row_q        <= '0;
            col_q        <= '0;
            cap_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            convert_q    <= 1'b0;
            read_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            t_erase_q    <= t_erase_d;
            t_expose_q   <= t_expose_d;
            t_convert_q  <= t_convert_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cap_q        <= cap_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            convert_q    <= convert_d;
            read_q       <= read_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign read       = read_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;

endmodule
